// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   ldr_state_t : loader sequencing states
//   IMEM_DEPTH  : instruction words in the memory
//   IMEM_AW     : word-address width
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        RUN    = 2'd3
    } ldr_state_t;

    localparam int IMEM_DEPTH = 64;
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH);

endpackage

// File: rtl/byte_packer.sv
// Packs an 8-bit byte stream into 32-bit little-endian words.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (drops any partial word)
//   in_valid_i      : byte accepted this cycle
//   in_data_i [7:0] : accepted byte
//   bcnt_o [1:0]    : lane the next accepted byte lands in
//   lane3_o         : combinational, the byte accepted now completes a word
//   word_o [31:0]   : last completed word (registered)
//   word_valid_o    : 1-cycle pulse the cycle after a word completes
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic [1:0]  bcnt_o,
    output logic        lane3_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  bcnt_q;
    logic [23:0] buf_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    assign lane3_o      = in_valid_i && (bcnt_q == 2'd3);
    assign bcnt_o       = bcnt_q;
    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q       <= 2'd0;
            buf_q        <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= lane3_o;
            if (in_valid_i) begin
                bcnt_q <= bcnt_q + 2'd1;
                case (bcnt_q)
                    2'd0: buf_q[7:0]   <= in_data_i;
                    2'd1: buf_q[15:8]  <= in_data_i;
                    2'd2: buf_q[23:16] <= in_data_i;
                    // Lane 3 completes the word straight from the lower lanes
                    // so the write issues exactly one cycle after the byte.
                    default: word_q <= {in_data_i, buf_q};
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader for the 64x32 instruction memory: streams a program in byte by
// byte, holds the CPU in reset while loading and releases it when done.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   load_start         : 1-cycle load request (honoured in IDLE/RUN)
//   load_words [AW:0]  : requested word count, clamped to DEPTH
//   s_valid/s_data/s_ready : byte stream; a byte moves when s_valid && s_ready
//   pc [31:0]          : CPU fetch address
//   imem_a [31:0]      : memory address, pc in RUN else write pointer
//   imem_we / imem_wd  : registered memory write strobe and data
//   cpu_reset          : CPU held in reset
//   busy               : loading or committing
//   done               : 1-cycle pulse on entry to RUN after a load
//   words_loaded [AW:0]: words written by the current/last load
//   state_dbg [1:0]    : loader state (ldr_state_t encoding)
//   bcnt_dbg [1:0]     : next byte lane
// Handshake: a byte is transferred on a rising edge where s_valid and s_ready
// are both 1; s_ready does not depend on s_valid.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int DEPTH    = IMEM_DEPTH,
    parameter bit AUTO_RUN = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [AW:0]   load_words,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    input  logic [31:0]   pc,
    output logic [31:0]   imem_a,
    output logic          imem_we,
    output logic [31:0]   imem_wd,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   words_loaded,
    output logic [1:0]    state_dbg,
    output logic [1:0]    bcnt_dbg
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] WPTR_MAX = AW'(DEPTH - 1);

    ldr_state_t    state_q;
    logic [AW-1:0] wptr_q;
    logic [AW:0]   len_q;
    logic [AW:0]   words_loaded_q;
    logic          done_q;

    logic          byte_accept;
    logic          lane3;
    logic          word_valid;
    logic [31:0]   word;
    logic [1:0]    bcnt;
    logic [AW:0]   wcount_next;
    logic          last_word;

    assign byte_accept = s_valid && (state_q == LOAD);

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (byte_accept),
        .in_data_i    (s_data),
        .bcnt_o       (bcnt),
        .lane3_o      (lane3),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // While lane 3 of word k is being accepted, the write of word k-1 has
    // already retired, so wptr equals k here.
    assign wcount_next = {1'b0, wptr_q} + (AW+1)'(1);
    assign last_word   = lane3 && (wcount_next == len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= AUTO_RUN ? RUN : IDLE;
            wptr_q         <= '0;
            len_q          <= '0;
            words_loaded_q <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Pointer advances at the end of the write cycle so imem_a holds
            // the target address while imem_we is high.
            if (word_valid) begin
                words_loaded_q <= words_loaded_q + (AW+1)'(1);
                if (wptr_q != WPTR_MAX) begin
                    wptr_q <= wptr_q + AW'(1);
                end
            end
            case (state_q)
                IDLE, RUN: begin
                    if (load_start) begin
                        words_loaded_q <= '0;
                        if (load_words == '0) begin
                            state_q <= RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            len_q   <= (load_words > DEPTH_W) ? DEPTH_W : load_words;
                            wptr_q  <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (last_word) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_q <= RUN;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready      = (state_q == LOAD);
    assign busy         = (state_q == LOAD) || (state_q == COMMIT);
    assign cpu_reset    = reset || (state_q != RUN);
    assign imem_a       = (state_q == RUN) ? pc : {{(30-AW){1'b0}}, wptr_q, 2'b00};
    assign imem_we      = word_valid;
    assign imem_wd      = word;
    assign done         = done_q;
    assign words_loaded = words_loaded_q;
    assign state_dbg    = state_q;
    assign bcnt_dbg     = bcnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
    import imem_pkg::*;

    localparam int MAXC = 2048;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [6:0]  load_words;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [31:0] pc;
    logic [31:0] imem_a;
    logic        imem_we;
    logic [31:0] imem_wd;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [6:0]  words_loaded;
    logic [1:0]  state_dbg;
    logic [1:0]  bcnt_dbg;

    imem_boot_loader #(.DEPTH(64), .AUTO_RUN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_words   (load_words),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .pc           (pc),
        .imem_a       (imem_a),
        .imem_we      (imem_we),
        .imem_wd      (imem_wd),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded),
        .state_dbg    (state_dbg),
        .bcnt_dbg     (bcnt_dbg)
    );

    // clock / cycle counter
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard counters
    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // per-cycle expected timeline built from the load transactions
    bit          exp_cr[MAXC];
    bit          exp_rdy[MAXC];
    bit          exp_we[MAXC];
    bit          exp_done[MAXC];
    logic [31:0] exp_wd[MAXC];
    logic [31:0] exp_addr[MAXC];
    int          exp_wl[MAXC];

    function automatic void fill(input int c, input bit cr, input bit rdy);
        for (int i = c; i < MAXC; i++) begin
            exp_cr[i]  = cr;
            exp_rdy[i] = rdy;
        end
    endfunction

    function automatic void fill_wl(input int c, input int v);
        for (int i = c; i < MAXC; i++) exp_wl[i] = v;
    endfunction

    // transaction model state
    int         m_len;
    int         m_written;
    int         m_lane;
    logic [7:0] m_buf[4];
    int         last_word_cyc;

    // observed writes for literal checks
    logic [31:0] obs_a[$];
    logic [31:0] obs_d[$];
    int          obs_c[$];
    int          last_done_cyc = -1;
    int          done_cnt = 0;

    // compare process
    always @(negedge clk) begin : cmp
        int c;
        int wl;
        c = cyc;
        if (chk_en && c < MAXC) begin
            wl = exp_wl[c];
            chk("cpu_reset", 64'(cpu_reset), 64'(exp_cr[c]));
            chk("s_ready", 64'(s_ready), 64'(exp_rdy[c]));
            chk("imem_we", 64'(imem_we), 64'(exp_we[c]));
            chk("done", 64'(done), 64'(exp_done[c]));
            chk("words_loaded", 64'(words_loaded), 64'(wl));
            if (exp_we[c]) chk("imem_wd", 64'(imem_wd), 64'(exp_wd[c]));
            if (!reset) begin
                if (!exp_cr[c])     chk("imem_a_run", 64'(imem_a), 64'(pc));
                else if (exp_we[c]) chk("imem_a_wr", 64'(imem_a), 64'(exp_addr[c]));
                else                chk("imem_a_ptr", 64'(imem_a), 64'(((wl < 64) ? wl : 63) * 4));
            end
        end
        if (imem_we === 1'b1) begin
            obs_a.push_back(imem_a);
            obs_d.push_back(imem_wd);
            obs_c.push_back(c);
        end
        if (done === 1'b1) begin
            last_done_cyc = c;
            done_cnt++;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        load_start = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        pc         = pc + 32'd4;
    endtask

    task automatic start_load(input int lw);
        step();
        load_start = 1'b1;
        load_words = 7'(lw);
        fill_wl(cyc + 1, 0);
        if (lw == 0) begin
            exp_done[cyc + 1] = 1'b1;
        end else begin
            fill(cyc + 1, 1'b1, 1'b1);
            m_len     = (lw > 64) ? 64 : lw;
            m_written = 0;
            m_lane    = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) step();
        step();
        s_valid = 1'b1;
        s_data  = b;
        m_buf[m_lane] = b;
        m_lane++;
        if (m_lane == 4) begin
            k = cyc;
            m_lane = 0;
            exp_we[k + 1]   = 1'b1;
            exp_wd[k + 1]   = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            exp_addr[k + 1] = 32'(m_written * 4);
            m_written++;
            fill_wl(k + 2, m_written);
            last_word_cyc = k;
            if (m_written == m_len) begin
                fill(k + 1, 1'b1, 1'b0);
                fill(k + 2, 1'b0, 1'b0);
                exp_done[k + 2] = 1'b1;
            end
        end
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_d.delete();
        obs_c.delete();
    endtask

    // stimulus tables
    logic [7:0] t2_bytes[8] = '{8'h4B, 8'h20, 8'hA0, 8'hE3, 8'h0F, 8'h00, 8'h4F, 8'hE0};
    logic [7:0] t3_bytes[12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    int         t3_gaps[12] = '{0, 1, 2, 3, 0, 3, 1, 0, 2, 0, 1, 3};

    initial begin : main
        int w0_cyc;
        int dcnt0;
        reset      = 1'b1;
        load_start = 1'b0;
        load_words = 7'd0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        pc         = 32'd0;
        fill(0, 1'b1, 1'b0);
        fill_wl(0, 0);

        // 1: reset release, AUTO_RUN
        repeat (3) step();
        reset = 1'b0;
        pc    = 32'h0000_0010;
        fill(cyc, 1'b0, 1'b0);
        chk_en = 1'b1;
        @(negedge clk);
        chk("t1_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("t1_s_ready", 64'(s_ready), 64'd0);
        chk("t1_imem_a", 64'(imem_a), 64'h10);
        chk("t1_state", 64'(state_dbg), 64'(RUN));

        // 2: two words back-to-back
        clear_obs();
        start_load(2);
        for (int i = 0; i < 8; i++) begin
            send_byte(t2_bytes[i], 0);
            if (i == 3) w0_cyc = cyc;
        end
        repeat (3) step();
        @(negedge clk);
        chk("t2_nwrites", 64'(obs_a.size()), 64'd2);
        if (obs_a.size() == 2) begin
            chk("t2_w0", 64'(obs_d[0]), 64'hE3A0204B);
            chk("t2_w1", 64'(obs_d[1]), 64'hE04F000F);
            chk("t2_a1", 64'(obs_a[1]), 64'h4);
            chk("t2_lat0", 64'(obs_c[0] - w0_cyc), 64'd1);
            chk("t2_lat1", 64'(obs_c[1] - last_word_cyc), 64'd1);
        end
        chk("t2_done_lat", 64'(last_done_cyc - last_word_cyc), 64'd2);
        chk("t2_words_loaded", 64'(words_loaded), 64'd2);

        // s_valid in RUN must be ignored
        step();
        s_valid = 1'b1;
        s_data  = 8'h5A;
        repeat (2) step();

        // 3: three words with gaps
        clear_obs();
        start_load(3);
        for (int i = 0; i < 12; i++) send_byte(t3_bytes[i], t3_gaps[i]);
        repeat (3) step();
        @(negedge clk);
        chk("t3_nwrites", 64'(obs_a.size()), 64'd3);
        if (obs_a.size() == 3) begin
            chk("t3_a2", 64'(obs_a[2]), 64'h8);
            chk("t3_w0", 64'(obs_d[0]), 64'h44332211);
            chk("t3_w2", 64'(obs_d[2]), 64'hCCBBAA99);
        end

        // 4: zero-length load
        clear_obs();
        dcnt0 = done_cnt;
        start_load(0);
        repeat (3) step();
        @(negedge clk);
        chk("t4_nwrites", 64'(obs_a.size()), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt - dcnt0), 64'd1);
        chk("t4_state", 64'(state_dbg), 64'(RUN));

        // 5: reset after 6 of 8 bytes
        clear_obs();
        start_load(2);
        for (int i = 0; i < 6; i++) send_byte(t2_bytes[i], 0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        fill(cyc, 1'b0, 1'b0);
        fill_wl(cyc, 0);
        m_lane = 0;
        @(negedge clk);
        chk("t5_state", 64'(state_dbg), 64'(RUN));
        chk("t5_bcnt", 64'(bcnt_dbg), 64'd0);
        repeat (3) step();
        @(negedge clk);
        chk("t5_nwrites", 64'(obs_a.size()), 64'd1);

        // 6: clamp to 64 words, mid-load request ignored
        clear_obs();
        dcnt0 = done_cnt;
        start_load(100);
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                step();
                load_start = 1'b1;
                load_words = 7'd5;
            end
            send_byte(8'((i * 7 + 3) & 255), 0);
        end
        repeat (4) step();
        @(negedge clk);
        chk("t6_nwrites", 64'(obs_a.size()), 64'd64);
        if (obs_a.size() == 64) begin
            chk("t6_last_addr", 64'(obs_a[63]), 64'hFC);
            chk("t6_w0", 64'(obs_d[0]), 64'h18110A03);
        end
        chk("t6_words_loaded", 64'(words_loaded), 64'd64);
        chk("t6_done_cnt", 64'(done_cnt - dcnt0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
